// File: rtl/gcd_pkg.sv
// Shared types and default sizes for the subtractive-Euclid GCD engine.
// No logic; imported by gcd_step and gcd_core.
// Optional cycle counter is enabled with GCD_CYCLE_CNT_EN (see gcd_core).
package gcd_pkg;

    localparam int GCD_DATA_WIDTH = 4;
    localparam int GCD_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

endpackage

// File: rtl/gcd_step.sv
// One subtractive-Euclid step: compare a/b, produce reduced operands or the final result.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the outputs.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int DATA_WIDTH = GCD_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] next_a,
    output logic [DATA_WIDTH-1:0] next_b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    // Priority: b==0 or a==b gives a, then a==0 gives b, otherwise subtract the
    // smaller from the larger (the larger side is known, so no underflow).
    always_comb begin
        next_a = a;
        next_b = b;
        done   = 1'b0;
        result = a;
        if ((b == '0) || (a == b)) begin
            done   = 1'b1;
            result = a;
        end else if (a == '0) begin
            done   = 1'b1;
            result = b;
        end else if (a > b) begin
            next_a = a - b;
        end else begin
            next_b = b - a;
        end
    end

endmodule

// File: rtl/gcd_core.sv
// GCD engine: collects A and B via en/rdy, iterates gcd_step once per cycle, holds result until y_en.
// Latency: y_rdy rises N+1 cycles after CALC entry (N = subtractions performed).
// Backpressure: a_rdy/b_rdy drop once an operand is held or a result is pending; result held until y_en.
// Optional: define GCD_CYCLE_CNT_EN to add the saturating CALC-cycle counter and calc_cycles_o.
module gcd_core
    import gcd_pkg::*;
#(
    parameter int DATA_WIDTH = GCD_DATA_WIDTH
`ifdef GCD_CYCLE_CNT_EN
    ,
    parameter int CNT_WIDTH  = GCD_CNT_WIDTH
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  a_en,
    output logic                  a_rdy,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  b_en,
    output logic                  b_rdy,
    output logic [DATA_WIDTH-1:0] y_data,
    output logic                  y_rdy,
    input  logic                  y_en
`ifdef GCD_CYCLE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  calc_cycles_o
`endif
);

    gcd_state_e            state, state_nxt;
    logic [DATA_WIDTH-1:0] a_q, a_nxt;
    logic [DATA_WIDTH-1:0] b_q, b_nxt;
    logic                  a_loaded, a_loaded_nxt;
    logic                  b_loaded, b_loaded_nxt;
    logic [DATA_WIDTH-1:0] y_nxt;

    logic [DATA_WIDTH-1:0] step_a;
    logic [DATA_WIDTH-1:0] step_b;
    logic                  step_done;
    logic [DATA_WIDTH-1:0] step_result;

    logic a_cap;
    logic b_cap;

    gcd_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .a      (a_q),
        .b      (b_q),
        .next_a (step_a),
        .next_b (step_b),
        .done   (step_done),
        .result (step_result)
    );

    assign a_rdy = (state == IDLE) && !a_loaded;
    assign b_rdy = (state == IDLE) && !b_loaded;
    assign y_rdy = (state == DONE);
    assign a_cap = a_en && a_rdy;
    assign b_cap = b_en && b_rdy;

    // State and datapath registers; reset clears everything including the held result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            a_loaded <= 1'b0;
            b_loaded <= 1'b0;
            y_data   <= '0;
        end else begin
            state    <= state_nxt;
            a_q      <= a_nxt;
            b_q      <= b_nxt;
            a_loaded <= a_loaded_nxt;
            b_loaded <= b_loaded_nxt;
            y_data   <= y_nxt;
        end
    end

    // Next-state: capture operands independently in IDLE, step in CALC, hold in DONE.
    always_comb begin
        state_nxt    = state;
        a_nxt        = a_q;
        b_nxt        = b_q;
        a_loaded_nxt = a_loaded;
        b_loaded_nxt = b_loaded;
        y_nxt        = y_data;
        case (state)
            IDLE: begin
                if (a_cap) begin
                    a_nxt        = a_data;
                    a_loaded_nxt = 1'b1;
                end
                if (b_cap) begin
                    b_nxt        = b_data;
                    b_loaded_nxt = 1'b1;
                end
                if (a_loaded_nxt && b_loaded_nxt) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (step_done) begin
                    y_nxt        = step_result;
                    a_loaded_nxt = 1'b0;
                    b_loaded_nxt = 1'b0;
                    state_nxt    = DONE;
                end else begin
                    a_nxt = step_a;
                    b_nxt = step_b;
                end
            end
            DONE: begin
                if (y_en) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef GCD_CYCLE_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_inc;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // Count CALC cycles (final one included), saturating; publish alongside the result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q         <= '0;
            calc_cycles_o <= '0;
        end else if ((state == IDLE) && (state_nxt == CALC)) begin
            cnt_q <= '0;
        end else if (state == CALC) begin
            cnt_q <= cnt_inc;
            if (step_done) begin
                calc_cycles_o <= cnt_inc;
            end
        end
    end
`endif

endmodule
